ecc_secded_pipe_dec: RTL and testbench

ECC_SECDED_PIPE_DEC -- requirements
Module: ecc_secded_pipe_dec

---
 rtl/ecc_secded_pkg.sv | 60 ++++++
 rtl/ecc_secded_enc.sv | 24 ++
 rtl/ecc_secded_pipe_dec.sv | 174 +++++++++++++++++
 tb/tb_ecc_secded_pipe_dec.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_secded_pkg.sv
// rtl/ecc_secded_pkg.sv - shared types and constant functions for the extended-Hamming SECDED codec
package ecc_secded_pkg;

    localparam int SYN_MAX_W  = 7;
    localparam int MAX_DATA_W = 64;

    typedef logic [SYN_MAX_W-1:0] syndrome_t;

    typedef enum logic [1:0] {
        CLEAN,
        SERR_DATA,
        SERR_CHK,
        DERR
    } dec_result_e;

    // Smallest r with 2^r >= data_w + r + 1; the descending scan leaves the smallest hit.
    function automatic int calc_r(input int data_w);
        int r;
        r = 0;
        for (int k = SYN_MAX_W; k >= 1; k--) begin
            if ((1 << k) >= data_w + k + 1) begin
                r = k;
            end
        end
        return r;
    endfunction

    function automatic int calc_ecc_w(input int data_w);
        return calc_r(data_w) + 1;
    endfunction

    // Code position of data bit idx: the idx-th non-power-of-two position starting at 3.
    function automatic int data_pos(input int idx);
        int pos;
        int cnt;
        pos = 0;
        cnt = 0;
        for (int p = 3; p < (1 << SYN_MAX_W); p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) begin
                    pos = p;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] chk_mask(input int data_w, input int k);
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (i < data_w && ((data_pos(i) >> k) & 1) == 1) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/ecc_secded_enc.sv
// rtl/ecc_secded_enc.sv - combinational extended-Hamming check-bit generator
module ecc_secded_enc
    import ecc_secded_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int ECC_W  = calc_ecc_w(DATA_W)
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [ECC_W-1:0]  o_chk
);

    localparam int R = ECC_W - 1;

    logic [R-1:0] w_chk;

    for (genvar k = 0; k < R; k++) begin : g_chk
        localparam logic [MAX_DATA_W-1:0] MASK = chk_mask(DATA_W, k);
        assign w_chk[k] = ^(i_data & MASK[DATA_W-1:0]);
    end

    // Top bit makes the whole codeword even parity.
    assign o_chk = {(^i_data) ^ (^w_chk), w_chk};

endmodule

// File: rtl/ecc_secded_pipe_dec.sv
// rtl/ecc_secded_pipe_dec.sv - two-stage SECDED decoder with error counters
// Optional retransmit pulse on o_nack when ECC_SECDED_HARQ_NACK_EN is defined.
module ecc_secded_pipe_dec
    import ecc_secded_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int CNT_W  = 16,
    localparam int ECC_W  = calc_ecc_w(DATA_W),
    localparam int FLIT_W = DATA_W + ECC_W
) (
    input  logic              i_aclk,
    input  logic              i_aresetn,
    input  logic              i_enable_ecc,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [FLIT_W-1:0] i_flit,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_serr,
    output logic              o_derr,
    output logic [CNT_W-1:0]  o_serr_cnt,
    output logic [CNT_W-1:0]  o_derr_cnt,
    input  logic              i_cnt_clr,
    output logic              o_nack
);

    localparam int R = ECC_W - 1;
    localparam int N = DATA_W + R;

    logic [DATA_W-1:0] w_rx_data;
    logic [ECC_W-1:0]  w_rx_chk;
    logic [ECC_W-1:0]  w_calc_chk;
    logic [R-1:0]      w_syn;
    logic              w_par;
    logic              w_en;
    logic              w_xfer;

    logic              r_s1_valid;
    logic              r_s1_ecc_en;
    logic [DATA_W-1:0] r_s1_data;
    syndrome_t         r_s1_syn;
    logic              r_s1_par;

    logic              r_o_valid;
    logic [DATA_W-1:0] r_o_data;
    logic              r_o_serr;
    logic              r_o_derr;
    logic [CNT_W-1:0]  r_serr_cnt;
    logic [CNT_W-1:0]  r_derr_cnt;

    assign w_rx_data = i_flit[DATA_W-1:0];
    assign w_rx_chk  = i_flit[FLIT_W-1:DATA_W];

    ecc_secded_enc #(
        .DATA_W (DATA_W)
    ) u_enc (
        .i_data (w_rx_data),
        .o_chk  (w_calc_chk)
    );

    // Overall parity of the received word, folded through the regenerated top bit.
    assign w_syn = w_calc_chk[R-1:0] ^ w_rx_chk[R-1:0];
    assign w_par = w_calc_chk[R] ^ w_rx_chk[R] ^ (^w_syn);

    assign w_en    = i_ready | ~r_o_valid;
    assign o_ready = w_en;
    assign w_xfer  = r_o_valid & i_ready;

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_s1_valid  <= 1'b0;
            r_s1_ecc_en <= 1'b0;
            r_s1_data   <= '0;
            r_s1_syn    <= '0;
            r_s1_par    <= 1'b0;
        end else if (w_en) begin
            r_s1_valid  <= i_valid;
            r_s1_ecc_en <= i_enable_ecc;
            r_s1_data   <= w_rx_data;
            r_s1_syn    <= syndrome_t'(w_syn);
            r_s1_par    <= w_par;
        end
    end

    dec_result_e       w_result;
    logic              w_syn_zero;
    logic              w_syn_pow2;
    logic              w_syn_in_range;
    logic [DATA_W-1:0] w_flip;
    logic [DATA_W-1:0] w_corr_data;

    assign w_syn_zero     = (r_s1_syn == '0);
    assign w_syn_pow2     = ((r_s1_syn & (r_s1_syn - syndrome_t'(1))) == '0);
    assign w_syn_in_range = (r_s1_syn <= syndrome_t'(N));

    always_comb begin
        w_result = CLEAN;
        if (r_s1_ecc_en) begin
            if (!r_s1_par) begin
                w_result = w_syn_zero ? CLEAN : DERR;
            end else if (w_syn_zero || w_syn_pow2) begin
                w_result = SERR_CHK;
            end else if (w_syn_in_range) begin
                w_result = SERR_DATA;
            end else begin
                w_result = DERR;
            end
        end
    end

    for (genvar i = 0; i < DATA_W; i++) begin : g_flip
        localparam int POS = data_pos(i);
        assign w_flip[i] = (w_result == SERR_DATA) && (r_s1_syn == syndrome_t'(POS));
    end

    assign w_corr_data = r_s1_data ^ w_flip;

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
            r_o_serr  <= 1'b0;
            r_o_derr  <= 1'b0;
        end else if (w_en) begin
            r_o_valid <= r_s1_valid;
            r_o_data  <= w_corr_data;
            r_o_serr  <= r_s1_valid & ((w_result == SERR_DATA) | (w_result == SERR_CHK));
            r_o_derr  <= r_s1_valid & (w_result == DERR);
        end
    end

    // Clear wins over a same-cycle increment; counts stick at all-ones.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_serr_cnt <= '0;
            r_derr_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_serr_cnt <= '0;
            r_derr_cnt <= '0;
        end else begin
            if (w_xfer && r_o_serr && !(&r_serr_cnt)) begin
                r_serr_cnt <= r_serr_cnt + CNT_W'(1);
            end
            if (w_xfer && r_o_derr && !(&r_derr_cnt)) begin
                r_derr_cnt <= r_derr_cnt + CNT_W'(1);
            end
        end
    end

`ifdef ECC_SECDED_HARQ_NACK_EN
    logic r_nack;

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_nack <= 1'b0;
        end else begin
            r_nack <= w_xfer & r_o_derr;
        end
    end

    assign o_nack = r_nack;
`else
    assign o_nack = 1'b0;
`endif

    assign o_valid    = r_o_valid;
    assign o_data     = r_o_data;
    assign o_serr     = r_o_serr;
    assign o_derr     = r_o_derr;
    assign o_serr_cnt = r_serr_cnt;
    assign o_derr_cnt = r_derr_cnt;

endmodule

// File: tb/tb_ecc_secded_pipe_dec.sv
// tb/tb_ecc_secded_pipe_dec.sv - randomized scoreboard bench for ecc_secded_pipe_dec
module tb_ecc_secded_pipe_dec;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int R  = 6;
    localparam int EW = R + 1;
    localparam int N  = DW + R;
    localparam int FW = DW + EW;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en_ecc;
    logic          in_valid;
    logic          out_ready;
    logic [FW-1:0] flit;
    logic          out_valid;
    logic          ds_ready;
    logic [DW-1:0] out_data;
    logic          serr;
    logic          derr;
    logic [CW-1:0] serr_cnt;
    logic [CW-1:0] derr_cnt;
    logic          cnt_clr;
    logic          nack;
    logic [DW-1:0] enc_data;
    logic [EW-1:0] enc_chk;

    always #5 clk = ~clk;

    ecc_secded_pipe_dec #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .i_aclk       (clk),
        .i_aresetn    (rst_n),
        .i_enable_ecc (en_ecc),
        .i_valid      (in_valid),
        .o_ready      (out_ready),
        .i_flit       (flit),
        .o_valid      (out_valid),
        .i_ready      (ds_ready),
        .o_data       (out_data),
        .o_serr       (serr),
        .o_derr       (derr),
        .o_serr_cnt   (serr_cnt),
        .o_derr_cnt   (derr_cnt),
        .i_cnt_clr    (cnt_clr),
        .o_nack       (nack)
    );

    ecc_secded_enc #(
        .DATA_W (DW)
    ) u_ref_enc (
        .i_data (enc_data),
        .o_chk  (enc_chk)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pos_of(input int idx);
        int p;
        int c;
        p = 2;
        c = -1;
        while (c < idx) begin
            p++;
            if ((p & (p - 1)) != 0) c++;
        end
        return p;
    endfunction

    function automatic logic [EW-1:0] ref_chk(input logic [DW-1:0] d);
        logic [EW-1:0] c;
        int p;
        c = '0;
        for (int i = 0; i < DW; i++) begin
            p = pos_of(i);
            for (int k = 0; k < R; k++) begin
                if (((p >> k) & 1) == 1) c[k] = c[k] ^ d[i];
            end
        end
        c[R] = (^d) ^ (^c[R-1:0]);
        return c;
    endfunction

    // Walk the codeword by position: syndrome = XOR of set positions, plus overall parity.
    task automatic ref_decode(input logic [FW-1:0] f, input bit en,
                              output logic [DW-1:0] od, output bit s, output bit dd);
        int  syn;
        bit  par;
        int  di;
        bit  b;
        od  = f[DW-1:0];
        s   = 1'b0;
        dd  = 1'b0;
        syn = 0;
        par = 1'b0;
        di  = 0;
        if (en) begin
            for (int pos = 1; pos <= N; pos++) begin
                if ((pos & (pos - 1)) == 0) begin
                    b = f[DW + $clog2(pos)];
                end else begin
                    b = f[di];
                    di++;
                end
                if (b) syn = syn ^ pos;
                par = par ^ b;
            end
            par = par ^ f[FW-1];
            if (!par) begin
                dd = (syn != 0);
            end else if (syn > N) begin
                dd = 1'b1;
            end else begin
                s = 1'b1;
                for (int i = 0; i < DW; i++) begin
                    if (pos_of(i) == syn) od[i] = ~od[i];
                end
            end
        end
    endtask

    typedef struct {
        logic [DW-1:0] d;
        bit            s;
        bit            dd;
    } exp_t;

    exp_t exp_q[$];

    int            m_serr = 0;
    int            m_derr = 0;
    bit            m_nack = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_s;
    logic          prev_d;

    always @(negedge clk) begin
        exp_t e;
        bit   xfer;
        if (!rst_n) begin
            exp_q.delete();
            m_serr     = 0;
            m_derr     = 0;
            m_nack     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check_eq("serr_cnt", 64'(serr_cnt), 64'(m_serr));
            check_eq("derr_cnt", 64'(derr_cnt), 64'(m_derr));
            check_eq("nack", 64'(nack), 64'(m_nack));
            if (out_valid) check_eq("flag_excl", 64'(serr & derr), 64'(0));
            if (prev_stall) begin
                check_eq("hold_valid", 64'(out_valid), 64'(1));
                check_eq("hold_data", 64'(out_data), 64'(prev_data));
                check_eq("hold_serr", 64'(serr), 64'(prev_s));
                check_eq("hold_derr", 64'(derr), 64'(prev_d));
            end
            if (out_valid && !ds_ready) check_eq("ready_stall", 64'(out_ready), 64'(0));
            prev_stall = out_valid && !ds_ready;
            prev_data  = out_data;
            prev_s     = serr;
            prev_d     = derr;
            xfer   = out_valid && ds_ready;
            m_nack = 1'b0;
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("data", 64'(out_data), 64'(e.d));
                    check_eq("serr", 64'(serr), 64'(e.s));
                    check_eq("derr", 64'(derr), 64'(e.dd));
`ifdef ECC_SECDED_HARQ_NACK_EN
                    m_nack = e.dd;
`endif
                    if (!cnt_clr) begin
                        if (e.s && m_serr < CNT_MAX) m_serr++;
                        if (e.dd && m_derr < CNT_MAX) m_derr++;
                    end
                end
            end
            if (cnt_clr) begin
                m_serr = 0;
                m_derr = 0;
            end
        end
    end

    int stall_left = 0;
    bit rand_bp    = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
            ds_ready = 1'b0;
            stall_left--;
        end else begin
            ds_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [FW-1:0] flip, input bit en);
        logic [FW-1:0] f;
        exp_t          e;
        logic [DW-1:0] ed;
        bit            es;
        bit            edd;
        bit            acc;
        int            guard;
        enc_data = d;
        f = {ref_chk(d), d} ^ flip;
        ref_decode(f, en, ed, es, edd);
        e.d  = ed;
        e.s  = es;
        e.dd = edd;
        in_valid = 1'b1;
        flit     = f;
        en_ecc   = en;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            if (guard == 0) check_eq("enc_chk", 64'(enc_chk), 64'(ref_chk(d)));
            acc = out_ready;
            tick();
            guard++;
        end
        if (acc) exp_q.push_back(e);
        else check_eq("accept_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            tick();
            g++;
        end
        if (exp_q.size() != 0) check_eq("drain_timeout", 64'(exp_q.size()), 64'(0));
        tick();
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [FW-1:0] fm;
        int            a;
        int            b;
        int            kind;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        flit     = '0;
        en_ecc   = 1'b1;
        ds_ready = 1'b1;
        cnt_clr  = 1'b0;
        enc_data = '0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 64'(out_valid), 64'(0));
        check_eq("rst_serr", 64'(serr), 64'(0));
        check_eq("rst_derr", 64'(derr), 64'(0));
        check_eq("rst_nack", 64'(nack), 64'(0));
        check_eq("rst_data", 64'(out_data), 64'(0));
        check_eq("rst_scnt", 64'(serr_cnt), 64'(0));
        check_eq("rst_dcnt", 64'(derr_cnt), 64'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", 64'(out_ready), 64'(1));
        tick();

        send(32'hDEADBEEF, '0, 1'b1);
        drain();
        check_eq("clean_scnt", 64'(serr_cnt), 64'(0));

        send(32'h12345678, FW'(32'h20), 1'b1);
        drain();
        check_eq("data5_scnt", 64'(serr_cnt), 64'(1));

        fm = '0;
        fm[DW] = 1'b1;
        send(32'hA5A5F00F, fm, 1'b1);
        drain();
        check_eq("chk0_scnt", 64'(serr_cnt), 64'(2));

        send(32'hCAFEF00D, FW'(32'h0002_0008), 1'b1);
        drain();
        check_eq("dbl_dcnt", 64'(derr_cnt), 64'(1));

        send(32'h0F0F0F0F, FW'(32'hE000_0000), 1'b1);
        drain();
        check_eq("synhigh_dcnt", 64'(derr_cnt), 64'(2));

        fm = '0;
        fm[FW-1] = 1'b1;
        send(32'h5555AAAA, fm, 1'b1);
        drain();
        check_eq("top_scnt", 64'(serr_cnt), 64'(3));

        send(32'h76543210, FW'(32'h3), 1'b0);
        drain();
        check_eq("bypass_scnt", 64'(serr_cnt), 64'(3));
        check_eq("bypass_dcnt", 64'(derr_cnt), 64'(2));

        send(32'h11111111, '0, 1'b1);
        send(32'h22222222, FW'(32'h400), 1'b1);
        stall_left = 3;
        send(32'h33333333, '0, 1'b1);
        send(32'h44444444, '0, 1'b1);
        drain();

        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send($urandom, FW'(1) << $urandom_range(0, DW - 1), 1'b1);
        end
        drain();
        check_eq("serr_sat", 64'(serr_cnt), 64'(CNT_MAX));

        send(32'h89ABCDEF, FW'(32'h8), 1'b1);
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check_eq("clr_prio", 64'(serr_cnt), 64'(0));
        drain();

        send(32'h0BADF00D, FW'(32'h80), 1'b1);
        drain();
        send(32'hFEEDFACE, '0, 1'b1);
        send(32'hC0FFEE00, FW'(32'h1), 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("inflight_valid", 64'(out_valid), 64'(0));
        check_eq("inflight_scnt", 64'(serr_cnt), 64'(0));
        check_eq("inflight_dcnt", 64'(derr_cnt), 64'(0));
        check_eq("inflight_data", 64'(out_data), 64'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst2", 64'(out_ready), 64'(1));
        tick();
        send(32'h13579BDF, FW'(32'h100), 1'b1);
        drain();
        check_eq("post_rst_scnt", 64'(serr_cnt), 64'(1));

        rand_bp = 1'b1;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 4);
            fm   = '0;
            case (kind)
                1: fm[$urandom_range(0, DW - 1)] = 1'b1;
                2: fm[DW + $urandom_range(0, EW - 1)] = 1'b1;
                3, 4: begin
                    a = $urandom_range(0, FW - 1);
                    b = (a + $urandom_range(1, FW - 1)) % FW;
                    fm[a] = 1'b1;
                    fm[b] = 1'b1;
                end
                default: fm = '0;
            endcase
            cnt_clr = ($urandom_range(0, 19) == 0);
            send($urandom, fm, kind != 4);
        end
        cnt_clr = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
